// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and branch flush.
// Decode contents move to execute one cycle later, or are replaced by a bubble.
module id_ex_stage_reg #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            id_valid,
    input  logic            id_regwrite,
    input  logic            id_alusrc,
    input  logic [1:0]      id_aluop,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_memtoreg,
    input  logic            id_branch,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [3:0]      id_funct,
    output logic            ex_valid,
    output logic            ex_regwrite,
    output logic            ex_alusrc,
    output logic [1:0]      ex_aluop,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_memtoreg,
    output logic            ex_branch,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA_W-1:0] ex_rs1,
    output logic [RA_W-1:0] ex_rs2,
    output logic [RA_W-1:0] ex_rd,
    output logic [3:0]      ex_funct,
    output logic            hazard_stall
);

    logic            valid_q, valid_d;
    logic            regwrite_q, regwrite_d;
    logic            alusrc_q, alusrc_d;
    logic [1:0]      aluop_q, aluop_d;
    logic            memread_q, memread_d;
    logic            memwrite_q, memwrite_d;
    logic            memtoreg_q, memtoreg_d;
    logic            branch_q, branch_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [RA_W-1:0] rs1_q, rs1_d;
    logic [RA_W-1:0] rs2_q, rs2_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic [3:0]      funct_q, funct_d;
    logic            load_use;
    logic            bubble;

    // rs2 is compared for every format: an extra stall is harmless, a missed one is not.
    always_comb begin
        load_use = memread_q & valid_q & (rd_q != '0) &
                   ((rd_q == id_rs1) | (rd_q == id_rs2)) & id_valid;
    end

    // Stall contract: hazard_stall=1 means the upstream stages hold the current
    // decode instruction and re-present it next cycle; a flush overrides it
    // because the decode instruction is being discarded anyway.
    assign hazard_stall = load_use & ~flush;
    assign bubble       = flush | load_use;

    always_comb begin
        valid_d    = id_valid;
        regwrite_d = id_regwrite & id_valid;
        alusrc_d   = id_alusrc & id_valid;
        aluop_d    = id_valid ? id_aluop : 2'b00;
        memread_d  = id_memread & id_valid;
        memwrite_d = id_memwrite & id_valid;
        memtoreg_d = id_memtoreg & id_valid;
        branch_d   = id_branch & id_valid;
        pc_d       = id_pc;
        rs1_data_d = id_rs1_data;
        rs2_data_d = id_rs2_data;
        imm_d      = id_imm;
        rs1_d      = id_rs1;
        rs2_d      = id_rs2;
        rd_d       = id_rd;
        funct_d    = id_funct;
        if (bubble) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            alusrc_d   = 1'b0;
            aluop_d    = 2'b00;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            branch_d   = 1'b0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            funct_d    = 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            alusrc_q   <= 1'b0;
            aluop_q    <= 2'b00;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            branch_q   <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct_q    <= 4'h0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            alusrc_q   <= alusrc_d;
            aluop_q    <= aluop_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            branch_q   <= branch_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct_q    <= funct_d;
        end
    end

    assign ex_valid    = valid_q;
    assign ex_regwrite = regwrite_q;
    assign ex_alusrc   = alusrc_q;
    assign ex_aluop    = aluop_q;
    assign ex_memread  = memread_q;
    assign ex_memwrite = memwrite_q;
    assign ex_memtoreg = memtoreg_q;
    assign ex_branch   = branch_q;
    assign ex_pc       = pc_q;
    assign ex_rs1_data = rs1_data_q;
    assign ex_rs2_data = rs2_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs1      = rs1_q;
    assign ex_rs2      = rs2_q;
    assign ex_rd       = rd_q;
    assign ex_funct    = funct_q;

endmodule
